// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: bus stores to the TX address queue bytes
// in a small FIFO that an internal FSM drains onto the tx line LSB first.
module mmio_uart_tx #(
  parameter logic [7:0] TX_ADDR      = 8'hFE,
  parameter logic [7:0] STAT_ADDR    = 8'hFF,
  parameter int         DEPTH        = 4,
  parameter int         CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       tx,
  output logic       stat_sel,
  output logic [7:0] stat_data,
  output logic       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT           state, stateNext;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count;
  logic            hitQ, clrQ, overflow;
  logic            txHit, clrHit, push, clr, pop, accept, ovSet;
  logic            empty, full, lastTick;
  logic [BW-1:0]   baud, baudNext;
  logic [2:0]      bitIdx, bitNext;
  logic [7:0]      shift, shiftNext;
  logic            txReg, txNext;

  // A strobe held for several cycles only counts once: act on the rising edge of each hit.
  assign txHit  = we && (addr == TX_ADDR);
  assign clrHit = we && (addr == STAT_ADDR);
  assign push   = txHit && !hitQ;
  assign clr    = clrHit && !clrQ;
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop    = (state == IDLE) && !empty;
  assign accept = push && (!full || pop);
  assign ovSet  = push && full && !pop;

  assign busy      = (state != IDLE);
  assign tx        = txReg;
  assign stat_sel  = (addr == STAT_ADDR) && !we;
  assign stat_data = {4'b0, overflow, busy, full, empty};

  always_ff @(posedge clock) begin
    if (accept) mem[wrPtr] <= wdata;
  end

  // A dropped byte sets overflow even when a clear lands on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      hitQ     <= 1'b0;
      clrQ     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      hitQ <= txHit;
      clrQ <= clrHit;
      if (accept) wrPtr <= wrPtr + PW'(1);
      if (pop)    rdPtr <= rdPtr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovSet)    overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      baud   <= '0;
      bitIdx <= '0;
      shift  <= '0;
      txReg  <= 1'b1;
    end else begin
      state  <= stateNext;
      baud   <= baudNext;
      bitIdx <= bitNext;
      shift  <= shiftNext;
      txReg  <= txNext;
    end
  end

  assign lastTick = (baud == BW'(CLKS_PER_BIT - 1));

  // txNext is the line level for the state being entered, so tx changes right on the edge.
  always_comb begin
    stateNext = state;
    baudNext  = baud;
    bitNext   = bitIdx;
    shiftNext = shift;
    txNext    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          stateNext = START;
          shiftNext = mem[rdPtr];
          baudNext  = '0;
          txNext    = 1'b0;
        end
      end
      START: begin
        txNext = 1'b0;
        if (lastTick) begin
          stateNext = DATA;
          baudNext  = '0;
          bitNext   = '0;
          txNext    = shift[0];
        end else begin
          baudNext = baud + BW'(1);
        end
      end
      DATA: begin
        txNext = shift[0];
        if (lastTick) begin
          baudNext  = '0;
          shiftNext = {1'b0, shift[7:1]};
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitNext = bitIdx + 3'd1;
            txNext  = shift[1];
          end
        end else begin
          baudNext = baud + BW'(1);
        end
      end
      STOP: begin
        if (lastTick) begin
          stateNext = IDLE;
          baudNext  = '0;
        end else begin
          baudNext = baud + BW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped serial transmit peripheral on the CPU/memory bus, downstream of the CPU store path.
- Snoops `we`, address (`mar`) and data (`mbr`). A store to TX_ADDR queues a byte in a small FIFO.
- An internal FSM serialises queued bytes as 8N1 frames on `tx`.
- A status byte is presented for top-level read muxing.

Parameters:
- TX_ADDR, 8'hFE, store address that enqueues a byte.
- STAT_ADDR, 8'hFF, status address; a store here clears the overflow flag; a read here selects the status byte.
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- CLKS_PER_BIT, 4, clock cycles per serial bit (≥2).

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- we, input, 1, bus write strobe.
- addr, input, 8, bus address.
- wdata, input, 8, bus data during a write.
- tx, output, 1, serial line; idle high.
- stat_sel, output, 1, combinational: `addr == STAT_ADDR && !we`. Top level drives `stat_data` onto the bus when it is high.
- stat_data, output, 8, `{4'b0, overflow, busy, full, empty}`.
- busy, output, 1, high while the FSM is not IDLE.

Behaviour:
- Reset (asynchronous): FIFO emptied, rd/wr pointers cleared, overflow=0, FSM=IDLE, tx=1, busy=0, edge-detect register=0. Resulting outputs: stat_data=8'h01, stat_sel follows its inputs.
- Write hit: `hit = we && addr == TX_ADDR`.
  - Push only on the first cycle of a contiguous hit (rising edge of hit, using a registered `hit_q`).
  - A strobe held N cycles enqueues once.
- Push when not full: `wdata` is written at the write pointer and count increments.
- Push when full and no pop in the same cycle: byte dropped, overflow set (sticky).
- Push and pop in the same cycle: both take effect, count unchanged, never overflow, even if full.
- Overflow clear: a write to STAT_ADDR clears overflow (edge-qualified like TX hits). If a set and a clear land in the same cycle, set wins.
- empty = (count == 0); full = (count == DEPTH). The count is wide enough to hold DEPTH. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP. Bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If !empty: pop the head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit 7, go to STOP. Data is sent LSB first.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - tx is registered (no glitches).
- Frame length is 10*CLKS_PER_BIT cycles. IDLE costs one cycle between back-to-back frames, so the frame period is 10*CLKS_PER_BIT+1.
- Latency:
  - Push at edge N into an empty FIFO with the FSM in IDLE.
  - Edge N+1: FSM pops, state=START, tx falls after edge N+1.
  - busy rises after edge N+1.
- Reset mid-frame: frame aborted, tx high immediately, queued bytes discarded.
- The CPU stores only to 8'hF0–8'hFF. Writes to other addresses are ignored, and reads never disturb the FIFO.

Test Plan (CLKS_PER_BIT=4, DEPTH=4):
- Reset asserted, then released → tx=1, stat_data=8'h01, busy=0. Reassert reset mid-frame → tx=1 within the same cycle, and stat_data=8'h01 after release.
- Single store of 8'hA5 to 8'hFE (we high 1 cycle) → tx low starting 1 cycle later for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. busy high for 40 cycles, then stat_data=8'h01.
- we held 3 cycles at 8'hFE with wdata=8'h3C → exactly one frame of 8'h3C is sent; FIFO count never exceeds 1.
- Six single-cycle stores 8'h01..8'h06 spaced 2 cycles apart:
  - Byte 01 is popped immediately; 02..05 fill the FIFO (full=1); 06 is dropped → overflow=1.
  - Frames out in order: 01, 02, 03, 04, 05.
  - stat_data goes to 8'h0E while full (overflow, busy and full bits set); after the FIFO drains, stat_data=8'h0C (overflow and busy set).
- Store to 8'hFF → overflow clears the next cycle. Store to 8'hFE on the exact cycle the FSM pops while full → byte accepted, overflow stays 0.
- addr=8'hFF with we=0 → stat_sel=1. With we=1 → stat_sel=0. Store to 8'hF3 → no enqueue, tx idle.
